// File: rtl/surf_cmd_receiver_pkg.sv
// Shared types and frame geometry for the SURF serial command receiver.
package surf_cmd_pkg;

  localparam int CMD_PAYLOAD_BITS = 34;
  localparam int CMD_FRAME_BITS   = 37;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } cmd_state_e;

  typedef struct packed {
    logic [1:0]  buffer;
    logic [31:0] id;
  } cmd_frame_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      cnt_q <= '0;
    else if (inc_i && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/surf_cmd_receiver.sv
// Deserializes TURF command frames (start, buffer, ID, parity, stop) into a
// one-deep valid/ready holding register and keeps frame/error statistics.
module surf_cmd_receiver
  import surf_cmd_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk33_i,
  input  logic             rst_i,
  input  logic             CMD_i,
  input  logic             evt_ready_i,
  output logic             evt_valid_o,
  output logic [1:0]       evt_buffer_o,
  output logic [31:0]      evt_id_o,
  output logic             digitize_o,
  output logic [CNT_W-1:0] frame_count_o,
  output logic [ERR_W-1:0] parity_err_o,
  output logic [ERR_W-1:0] framing_err_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam int          BCNT_W   = $clog2(CMD_PAYLOAD_BITS);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(CMD_PAYLOAD_BITS - 1);

  cmd_state_e                  state_q;
  logic                        cmd_q;
  logic [BCNT_W-1:0]           bit_cnt_q;
  logic [CMD_PAYLOAD_BITS-1:0] shift_q;
  logic                        par_q;
  logic                        perr_q;
  cmd_frame_t                  held_q;
  logic                        evt_valid_q;
  logic                        dig_q;
  logic [CNT_W-1:0]            frame_cnt_q;
  logic                        ovf_q;

  logic accept, in_stop, stop_bad, par_bad, frame_good;

  assign accept     = evt_valid_q && evt_ready_i;
  assign in_stop    = (state_q == STOP);
  // Stop-bit error outranks parity error; only one counter moves per frame.
  assign stop_bad   = in_stop && cmd_q;
  assign par_bad    = in_stop && !cmd_q && perr_q;
  assign frame_good = in_stop && !cmd_q && !perr_q;

  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cmd_q       <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
      held_q      <= '0;
      evt_valid_q <= 1'b0;
      dig_q       <= 1'b0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cmd_q <= CMD_i;
      dig_q <= 1'b0;
      if (accept) evt_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cmd_q) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
          end
        end
        SHIFT: begin
          shift_q   <= {shift_q[CMD_PAYLOAD_BITS-2:0], cmd_q};
          par_q     <= par_q ^ cmd_q;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_q <= PARITY;
        end
        PARITY: begin
          perr_q  <= cmd_q ^ par_q;
          state_q <= STOP;
        end
        STOP: begin
          state_q <= IDLE;
          if (frame_good) begin
            dig_q       <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 1'b1;
            // A slot freed by this cycle's accept may be refilled immediately.
            if (!evt_valid_q || evt_ready_i) begin
              held_q      <= cmd_frame_t'(shift_q);
              evt_valid_q <= 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(ERR_W)) u_par_cnt (
    .clk_i (clk33_i),
    .rst_i (rst_i),
    .inc_i (par_bad),
    .cnt_o (parity_err_o)
  );

  sat_counter #(.W(ERR_W)) u_frm_cnt (
    .clk_i (clk33_i),
    .rst_i (rst_i),
    .inc_i (stop_bad),
    .cnt_o (framing_err_o)
  );

  assign evt_valid_o   = evt_valid_q;
  assign evt_buffer_o  = held_q.buffer;
  assign evt_id_o      = held_q.id;
  assign digitize_o    = dig_q;
  assign frame_count_o = frame_cnt_q;
  assign overflow_o    = ovf_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: doc/surf_cmd_receiver.md
# surf_cmd_receiver

SURF-side receiver for the per-SURF serial command line that the TURF trigger interface drives after each digitize decision. It deserializes one command frame into a buffer number and a 32-bit event ID, and checks parity and the stop bit. Each good frame is presented to SURF readout logic through a one-deep valid/ready holding register. Error statistics are kept in saturating counters readable by the SURF register map.

## Interface
Parameters:
- CNT_W, 16: width of the good-frame counter.
- ERR_W, 8: width of each error counter.

Ports:
- clk33_i  in  1  command clock; the line is synchronous to it, one bit per cycle.
- rst_i  in  1  asynchronous, active-high reset.
- CMD_i  in  1  serial command line; idles low.
- evt_ready_i  in  1  downstream accepts the held event.
- evt_valid_o  out  1  held event valid.
- evt_buffer_o  out  2  digitize buffer number of the held event.
- evt_id_o  out  32  event ID of the held event.
- digitize_o  out  1  one-cycle pulse when a good frame completes, whether kept or dropped.
- frame_count_o  out  CNT_W  good frames received; wraps.
- parity_err_o  out  ERR_W  parity errors; saturates.
- framing_err_o  out  ERR_W  stop-bit errors; saturates.
- overflow_o  out  1  sticky; set when a good frame is dropped because the holding register is full.
- busy_o  out  1  FSM not in IDLE.

## Operation
- Frame order on the line:
  - start bit (1)
  - buffer[1:0], MSB first
  - event ID[31:0], MSB first
  - even parity over the 34 payload bits
  - stop bit (0)
  - Total: 37 bits.
- CMD_i is registered once (cmd_q) before any use. No other synchronizer is used.
- FSM states:
  - IDLE: cmd_q=1 → SHIFT, bit counter cleared.
  - SHIFT: shift cmd_q into a 34-bit shift register and accumulate parity; after the 34th bit → PARITY.
  - PARITY: compare cmd_q with the accumulated parity → STOP.
  - STOP: evaluate the frame (below) → IDLE.
- Frame evaluation in STOP, in priority order:
  - Stop bit = 1: framing_err_o increments; the frame is discarded.
  - Parity mismatch: parity_err_o increments; the frame is discarded.
  - Otherwise the frame is good: digitize_o pulses and frame_count_o increments.
    - Holding register empty, or emptying this cycle: load buffer and ID, assert evt_valid_o.
    - Holding register full: drop the frame and set overflow_o.
- A framing error leaves the FSM in IDLE. If the line is still high, that is taken as a new start bit on the next cycle; no extra resynchronisation is done.
- Handshake: evt_valid_o stays high and its data stays stable until sampled with evt_ready_i=1.
  - If a load and an accept occur in the same cycle, the new event replaces the old one and evt_valid_o stays high.
- Counters: frame_count_o wraps modulo 2^CNT_W. The error counters stop at all-ones.
- overflow_o is cleared only by rst_i.

## Timing
- Reset values: all outputs 0, FSM in IDLE, shift register 0, cmd_q 0.
- Edge numbering, with edge 0 the clk33_i edge that registers the start bit into cmd_q:
  - Edges 1..34: payload bits shifted in.
  - Edge 35: parity checked.
  - Edge 36: stop bit checked.
  - Edge 37: evt_valid_o, evt_buffer_o and evt_id_o update, digitize_o pulses, and the relevant counter increments.
- busy_o is high from edge 1 through edge 36.
- Back-to-back frames are allowed: a start bit may be registered at edge 37, the same edge the previous frame's results appear.
- rst_i mid-frame aborts immediately: the partial frame is lost, no counter changes, and outputs return to their reset values.

## Structure
- Package surf_cmd_pkg holds:
  - CMD_PAYLOAD_BITS = 34
  - CMD_FRAME_BITS = 37
  - the FSM state enum (IDLE, SHIFT, PARITY, STOP)
  - a cmd_frame_t struct {buffer[1:0], id[31:0]}.
- One natural sub-module, sat_counter (width parameter, inc input, saturating), instantiated once for each error counter.

## Test plan
- Good frame, buffer=2, ID=0xDEADBEEF, evt_ready_i=1 → at edge 37 evt_valid_o=1, evt_buffer_o=2, evt_id_o=0xDEADBEEF; digitize_o pulses once; frame_count_o=1.
- Same frame with the parity bit flipped → no evt_valid_o and no digitize_o; parity_err_o=1; frame_count_o=0.
- Stop bit driven 1 → framing_err_o=1 and no event. Then a good frame with ID=0x00000001 → received correctly.
- evt_ready_i=0 and three back-to-back good frames with IDs 1, 2, 3 → evt_id_o holds 1; overflow_o=1; frame_count_o=3; digitize_o pulses 3 times.
- 300 frames with bad parity → parity_err_o saturates at 255 and stays there.
- rst_i asserted at edge 20 of a frame → all outputs 0 immediately. A following good frame with ID=0x12345678 → received correctly.
